// File: rtl/apb_pkg.sv
// Shared APB master types and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or above ptr wins.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          hit_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (en_i && !hit_o && req_i[cand]) begin
                hit_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB3 master sharing one slave port between N_REQ requesters.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W-1:0]       prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    apb_state_t        state_q, state_d;
    apb_cmd_t          cmd_q, cmd_d;
    logic [IW-1:0]     own_q, own_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;

    logic              arb_en;
    logic              arb_hit;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;

    // Arbitrate when idle, or on a completing ACCESS for back-to-back issue.
    assign arb_en = !preset &&
                    ((state_q == IDLE) ||
                     ((state_q == ACCESS) && pready));

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .hit_o (arb_hit)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        own_d        = own_q;
        ptr_d        = ptr_q;
        wait_d       = wait_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_slverr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                wait_d = '0;
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                wait_d = wait_q + CW'(1);
                if (pready) begin
                    rsp_valid_d[own_q] = 1'b1;
                    rsp_rdata_d  = cmd_q.write ? '0 : prdata;
                    rsp_slverr_d = pslverr;
                    wait_d       = '0;
                    state_d      = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    rsp_valid_d[own_q] = 1'b1;
                    rsp_slverr_d = 1'b1;
                    wait_d       = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arb_hit) begin
            cmd_d.write = req_write[arb_idx];
            cmd_d.addr  = APB_ADDR_W'(
                req_addr[int'(arb_idx)*ADDR_W +: ADDR_W]);
            cmd_d.wdata = APB_DATA_W'(
                req_wdata[int'(arb_idx)*DATA_W +: DATA_W]);
            own_d   = arb_idx;
            ptr_d   = (arb_idx == IW'(N_REQ - 1)) ?
                      '0 : arb_idx + IW'(1);
            state_d = SETUP;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            own_q        <= '0;
            ptr_q        <= '0;
            wait_q       <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            own_q        <= own_d;
            ptr_q        <= ptr_d;
            wait_q       <= wait_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign req_ready  = arb_gnt;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign psel       = (state_q != IDLE);
    assign penable    = (state_q == ACCESS);
    assign pwrite     = cmd_q.write;
    assign paddr      = cmd_q.addr[ADDR_W-1:0];
    assign pwdata     = cmd_q.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB RAM slave.
module tb_apb_master_arbiter;

    logic        pclk;
    logic        preset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master_arbiter dut (
        .pclk       (pclk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // APB RAM: 64 words below 0x100, error above; ws wait states or hang.
    logic [31:0] mem [64];
    int          acc_cnt;
    int          ws;
    logic        hang;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        acc_cnt = 0;
    end

    assign pready  = !hang && (acc_cnt >= ws);
    assign pslverr = psel && penable && (paddr >= 32'h100);
    assign prdata  = (paddr < 32'h100) ? mem[paddr[7:2]] : 32'h0;

    always @(posedge pclk) begin
        if (preset || !psel) begin
            acc_cnt <= 0;
        end else if (penable && !pready) begin
            acc_cnt <= acc_cnt + 1;
        end else if (penable && pready) begin
            acc_cnt <= 0;
            if (pwrite && paddr < 32'h100) mem[paddr[7:2]] <= pwdata;
        end
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int r, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err,
                        output logic [1:0] vec, output int lat,
                        output logic stab);
        int n;
        rd = 32'h0; err = 1'b0; vec = 2'b00; lat = 0; stab = 1'b1;
        @(negedge pclk);
        req_write[r]         = wr;
        req_addr[r*32 +: 32]  = a;
        req_wdata[r*32 +: 32] = d;
        req_valid[r]         = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("accept", 64'(req_ready[r]), 64'd1);
        if (!req_ready[r]) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge pclk);
        req_valid[r] = 1'b0;
        #1;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 40) begin
            if (psel && (paddr != a || pwrite != wr ||
                         (wr && pwdata != d)))
                stab = 1'b0;
            @(negedge pclk);
            #1;
            lat++;
        end
        chk("rsp_seen", 64'(rsp_valid != 2'b00), 64'd1);
        rd  = rsp_rdata;
        err = rsp_slverr;
        vec = rsp_valid;
    endtask

    logic [1:0]  acc;
    logic [1:0]  gord [4];
    logic [1:0]  rord [4];
    int          ng;
    int          nr;
    logic [9:0]  pat;

    task automatic csample(input int c);
        #1;
        if (req_ready != 2'b00) begin
            if (ng < 4) gord[ng] = req_ready;
            ng++;
            acc = req_ready;
        end
        if (rsp_valid != 2'b00) begin
            if (nr < 4) rord[nr] = rsp_valid;
            nr++;
        end
        pat[c] = psel;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [1:0]  vec;
    int          lat;
    logic        stab;
    int          n;
    logic        seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        hang    = 1'b0;
        ws      = 0;
        for (int i = 0; i < 4; i++) begin
            gord[i] = 2'b00;
            rord[i] = 2'b00;
        end

        // Reset with both requesters already valid.
        preset    = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {32'h14, 32'h10};
        req_wdata = {32'h22, 32'h11};
        repeat (3) @(negedge pclk);
        #1;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_rdata}, 64'd0);
        chk("rst_bus", {pwrite, paddr, 31'd0}, 64'd0);

        // Contention: grant 0 then 1, back-to-back.
        preset = 1'b0;
        acc = 2'b00; ng = 0; nr = 0; pat = '0;
        csample(0);
        for (int c = 1; c < 10; c++) begin
            @(negedge pclk);
            req_valid = req_valid & ~acc;
            acc = 2'b00;
            csample(c);
        end
        chk("c_gnt0", 64'(gord[0]), 64'd1);
        chk("c_gnt1", 64'(gord[1]), 64'd2);
        chk("c_ngnt", 64'(ng), 64'd2);
        chk("c_rsp0", 64'(rord[0]), 64'd1);
        chk("c_rsp1", 64'(rord[1]), 64'd2);
        chk("c_b2b_psel", 64'(pat), 64'h1E);

        xfer(0, 1'b0, 32'h10, 32'h0, rd, er, vec, lat, stab);
        chk("c_rd0", 64'(rd), 64'h11);
        chk("c_rd0_vec", 64'(vec), 64'd1);
        xfer(1, 1'b0, 32'h14, 32'h0, rd, er, vec, lat, stab);
        chk("c_rd1", 64'(rd), 64'h22);
        chk("c_rd1_vec", 64'(vec), 64'd2);

        // Single write then read.
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, er, vec, lat, stab);
        chk("w_lat", 64'(lat), 64'd3);
        chk("w_err", 64'(er), 64'd0);
        chk("w_rdata", 64'(rd), 64'd0);
        chk("w_vec", 64'(vec), 64'd1);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, er, vec, lat, stab);
        chk("r_data", 64'(rd), 64'hDEADBEEF);
        chk("r_lat", 64'(lat), 64'd3);
        chk("r_err", 64'(er), 64'd0);

        // Three wait states.
        ws = 3;
        xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, rd, er, vec, lat, stab);
        chk("ws_lat", 64'(lat), 64'd6);
        chk("ws_stable", 64'(stab), 64'd1);
        chk("ws_err", 64'(er), 64'd0);
        ws = 0;

        // Slave error on requester 1 only.
        xfer(1, 1'b0, 32'h100, 32'h0, rd, er, vec, lat, stab);
        chk("se_err", 64'(er), 64'd1);
        chk("se_vec", 64'(vec), 64'd2);
        chk("se_rdata", 64'(rd), 64'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, er, vec, lat, stab);
        chk("se_other_err", 64'(er), 64'd0);
        chk("se_other_rd", 64'(rd), 64'hDEADBEEF);

        // Timeout after 16 ACCESS cycles.
        hang = 1'b1;
        xfer(0, 1'b0, 32'h04, 32'h0, rd, er, vec, lat, stab);
        chk("to_lat", 64'(lat), 64'd18);
        chk("to_err", 64'(er), 64'd1);
        chk("to_rdata", 64'(rd), 64'd0);
        chk("to_vec", 64'(vec), 64'd1);
        chk("to_psel", 64'(psel), 64'd0);
        hang = 1'b0;
        xfer(1, 1'b0, 32'h20, 32'h0, rd, er, vec, lat, stab);
        chk("to_next_rd", 64'(rd), 64'hCAFEF00D);
        chk("to_next_lat", 64'(lat), 64'd3);
        chk("to_next_err", 64'(er), 64'd0);

        // Reset in the middle of ACCESS.
        hang = 1'b1;
        @(negedge pclk);
        req_write[0]     = 1'b0;
        req_addr[31:0]   = 32'h04;
        req_valid[0]     = 1'b1;
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("ra_accept", 64'(req_ready[0]), 64'd1);
        @(negedge pclk);
        req_valid[0] = 1'b0;
        @(negedge pclk);
        #1;
        chk("ra_in_access", 64'(penable), 64'd1);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        chk("ra_psel", 64'(psel), 64'd0);
        chk("ra_penable", 64'(penable), 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge pclk);
            seen = seen | (rsp_valid != 2'b00);
        end
        preset    = 1'b0;
        hang      = 1'b0;
        req_write = 2'b00;
        req_addr  = {32'h14, 32'h04};
        req_valid = 2'b11;
        #1;
        chk("ra_ptr_zero", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        repeat (2) begin
            @(negedge pclk);
            seen = seen | (rsp_valid != 2'b00);
        end
        chk("ra_no_rsp", 64'(seen), 64'd0);
        xfer(1, 1'b0, 32'h14, 32'h0, rd, er, vec, lat, stab);
        chk("ra_r1_vec", 64'(vec), 64'd2);
        chk("ra_r1_rd", 64'(rd), 64'h22);
        chk("ra_r1_lat", 64'(lat), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Round-robin APB3 master that shares one APB slave port (the apb_ram) between N_REQ local requesters.
- Each requester issues single read/write commands over a valid/ready handshake.
- The block serialises the commands into legal SETUP/ACCESS APB transfers and returns read data and error status to the winning requester.
- It sits between the testbench/generator-side requesters and apb_ram, and owns psel, penable, pwrite, paddr and pwdata.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before forced error completion.

Ports:
- pclk  in  1  APB clock, rising-edge.
- preset  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester command valid.
- req_ready  out  N_REQ  one-hot command accept pulse.
- req_write  in  N_REQ  per-requester direction, 1=write.
- req_addr  in  N_REQ*ADDR_W  packed per-requester address, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed per-requester write data.
- rsp_valid  out  N_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid; 0 for writes.
- rsp_slverr  out  1  error status, valid with rsp_valid.
- psel, penable, pwrite  out  1 each  APB master controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Interface: one clock pclk; reset preset is synchronous and active-high.
- Reset state:
  - Every output is 0; state is IDLE.
  - rr_ptr = 0; wait counter = 0.
  - Reset asserted mid-transfer drops psel/penable at that edge; no rsp_valid is issued for the aborted command.
- States: IDLE, SETUP, ACCESS, all registered outputs.
- IDLE:
  - If any req_valid: grant g = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - Pulse req_ready[g] combinationally in that cycle.
  - Latch req_write/addr/wdata of g into the command register; set rr_ptr = (g+1) mod N_REQ; go SETUP.
  - If no req_valid: stay in IDLE with psel=0.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the command register. Always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable; wait counter increments each cycle.
  - If pready=1:
    - Pulse rsp_valid[g] for 1 cycle (registered, in the cycle after the pready edge).
    - rsp_rdata = prdata when pwrite=0, else 0; rsp_slverr = pslverr.
    - If any req_valid: perform the IDLE arbitration in this same cycle and go directly to SETUP (back-to-back; psel stays 1, penable drops).
    - Otherwise go IDLE.
  - If the wait counter reaches TIMEOUT-1 with pready=0: complete with rsp_slverr=1 and rsp_rdata=0, drop psel/penable, go IDLE.
- Latency: req accept to rsp_valid is 3 cycles with zero slave wait states, plus 1 cycle per pready=0 cycle.
- Requester rules:
  - A requester holds valid and fields until it sees req_ready.
  - At most one req_ready bit and one rsp_valid bit are set per cycle.
  - req_valid deasserted before acceptance is legal (withdrawn).
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
- Simultaneous events: completion of requester g and a new request from g in the same cycle → the new request loses priority to the others; rr_ptr has already advanced past g.
- pslverr is sampled only when psel & penable & pready are all high.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS}.
  - typedef apb_cmd_t struct {write, addr, wdata}.
  - Default width constants APB_ADDR_W and APB_DATA_W.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt[N] and an index.
  - Purely combinational priority rotate, reused by future multi-master APB blocks.

Test Plan:
- Single write then read (pready tied 1): requester 0 writes addr 0x04 data 0xDEADBEEF, then reads 0x04 → rsp_valid[0] 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- Contention: both requesters valid from reset (req0 write 0x10=0x11, req1 write 0x14=0x22) → grant order 0 then 1; back-to-back transfers with no IDLE cycle between; reads return 0x11 and 0x22.
- Wait states: slave holds pready=0 for 3 ACCESS cycles → paddr/pwdata stable throughout, rsp_valid exactly 6 cycles after accept.
- Slave error: read of out-of-range addr 0x100 with pslverr=1 → rsp_slverr=1 for that requester only.
- Timeout: pready held 0 → after 16 ACCESS cycles, rsp_slverr=1 and rsp_rdata=0, psel=0, state IDLE; the next request proceeds normally.
- Reset mid-ACCESS: assert preset during ACCESS → psel=penable=0 next edge, no rsp_valid, rr_ptr=0; requester 1 alone valid afterwards → granted.
